clk_div_bank: RTL

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_chan.sv | 72 +++++++
 rtl/clk_div_bank.sv | 47 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clock divider bank.
package clk_div_pkg;
  localparam int CW_DEF   = 16;
  localparam int HALF_DEF = 8;

  // Width of a channel index; never below one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active half-period, shadow divisor, counter and square-wave output.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW           = CW_DEF,
  parameter int DEFAULT_HALF = HALF_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          we,
  input  logic [CW-1:0] half,
  output logic          clk_out,
  output logic          tick,
  output logic          pending
);
  logic [CW-1:0] h;
  logic [CW-1:0] s;
  logic [CW-1:0] cnt;
  logic          at_end;
  logic          apply;

  // A new divisor lands only on the falling boundary (or at once when disabled),
  // so the wave never shows a truncated phase.
  always_comb begin
    at_end = (h != '0) && (cnt == h - CW'(1));
    apply  = pending && ((h == '0) || (at_end && clk_out));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h       <= CW'(DEFAULT_HALF);
      s       <= CW'(DEFAULT_HALF);
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (we) begin
        s       <= half;
        pending <= 1'b1;
      end
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          h <= s;
          if (!we) pending <= 1'b0;
        end
      end else if (apply) begin
        // Old shadow is used; a same-cycle write stays queued.
        h       <= s;
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (!we) pending <= 1'b0;
      end else if (h == '0) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (at_end) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent 50%-duty clock dividers sharing one config write port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int CW           = CW_DEF,
  parameter int DEFAULT_HALF = HALF_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [ch_w(NCH)-1:0]   cfg_ch,
  input  logic [CW-1:0]          cfg_half,
  input  logic                   sync,
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         pending
);
  localparam int CHW = ch_w(NCH);

  // cfg_we is a fire-and-forget strobe with no ready: every accepted write lands
  // on the next edge. Indices at or above NCH match no channel and are dropped.
  logic [NCH-1:0] we_sel;

  always_comb begin
    we_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      we_sel[i] = cfg_we && (cfg_ch == CHW'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CW           (CW),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sync    (sync),
      .we      (we_sel[i]),
      .half    (cfg_half),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule
